// File: rtl/demux_1xn_fifo_pkg.sv
// Shared defaults for the 1:N FIFO demux: default geometry and the error-counter
// width/saturation value used when DEMUX_ERR_CNT_EN is defined.
package demux_1xn_fifo_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_N_OUT  = 4;
   localparam int DEF_DEPTH  = 4;

   localparam int                   ERR_CNT_W   = 16;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO; the head word is read straight
// from registered storage and the last popped head is held while empty.
module fifo_sync
   import demux_1xn_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   // Empty FIFO presents the last head it delivered (zero after reset).
   assign dout    = empty ? hold_q : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      hold_d   = hold_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         hold_d   = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         hold_q   <= hold_d;
      end
   end

   // Storage needs no reset: it is only observable through a non-zero count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/demux_1xn_fifo.sv
// 1:N valid/ready demux with a FWFT FIFO per output channel.
// Optional out-of-range drop counter on port err_cnt when DEMUX_ERR_CNT_EN is defined.
module demux_1xn_fifo
   import demux_1xn_fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int N_OUT  = DEF_N_OUT,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int SEL_W  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_W-1:0]       Entrada,
   input  logic                    validEntrada,
   input  logic [SEL_W-1:0]        selector,
   output logic                    readyEntrada,
   output logic [N_OUT*DATA_W-1:0] Salida,
   output logic [N_OUT-1:0]        validSalida,
   input  logic [N_OUT-1:0]        readySalida,
   output logic [N_OUT-1:0]        fullSalida
`ifdef DEMUX_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0]    err_cnt
`endif
);

   // Handshake: a word moves on any rising edge where valid and ready are both 1.
   // readyEntrada looks only at registered full flags, never at readySalida.
   logic [N_OUT-1:0] sel_hot;
   logic [N_OUT-1:0] push_vec;
   logic [N_OUT-1:0] pop_vec;
   logic [N_OUT-1:0] empty_vec;
   logic             sel_full;
   logic             sel_in_range;
   logic             transfer;

   always_comb begin
      sel_hot  = '0;
      sel_full = 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
         if (selector == SEL_W'(k)) begin
            sel_hot[k] = 1'b1;
            sel_full   = fullSalida[k];
         end
      end
   end

   assign sel_in_range = |sel_hot;
   assign readyEntrada = !reset && (!sel_in_range || !sel_full);
   assign transfer     = validEntrada && readyEntrada;
   assign push_vec     = transfer ? sel_hot : '0;
   assign validSalida  = ~empty_vec;
   assign pop_vec      = reset ? '0 : (validSalida & readySalida);

   for (genvar g = 0; g < N_OUT; g++) begin : g_ch
      fifo_sync #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push_vec[g]),
         .din   (Entrada),
         .pop   (pop_vec[g]),
         .dout  (Salida[g*DATA_W +: DATA_W]),
         .empty (empty_vec[g]),
         .full  (fullSalida[g])
      );
   end

`ifdef DEMUX_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (transfer && !sel_in_range && (err_cnt_q != ERR_CNT_MAX)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_demux_1xn_fifo.sv
// Directed bench for demux_1xn_fifo: a 4-channel instance plus a 3-channel
// instance for the out-of-range selector case; err_cnt checked with DEMUX_ERR_CNT_EN.
module tb_demux_1xn_fifo;

   logic        clk;
   logic        reset;

   logic [7:0]  ent;
   logic        val;
   logic [1:0]  sel;
   logic        rdy_in;
   logic [31:0] sal;
   logic [3:0]  vsal;
   logic [3:0]  rsal;
   logic [3:0]  fsal;

   logic [7:0]  ent3;
   logic        val3;
   logic [1:0]  sel3;
   logic        rdy_in3;
   logic [23:0] sal3;
   logic [2:0]  vsal3;
   logic [2:0]  rsal3;
   logic [2:0]  fsal3;

`ifdef DEMUX_ERR_CNT_EN
   logic [15:0] err4;
   logic [15:0] err3;
`endif

   int checks;
   int errors;

   demux_1xn_fifo #(.DATA_W(8), .N_OUT(4), .DEPTH(4), .SEL_W(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .Entrada      (ent),
      .validEntrada (val),
      .selector     (sel),
      .readyEntrada (rdy_in),
      .Salida       (sal),
      .validSalida  (vsal),
      .readySalida  (rsal),
      .fullSalida   (fsal)
`ifdef DEMUX_ERR_CNT_EN
      ,
      .err_cnt      (err4)
`endif
   );

   demux_1xn_fifo #(.DATA_W(8), .N_OUT(3), .DEPTH(4), .SEL_W(2)) dut3 (
      .clk          (clk),
      .reset        (reset),
      .Entrada      (ent3),
      .validEntrada (val3),
      .selector     (sel3),
      .readyEntrada (rdy_in3),
      .Salida       (sal3),
      .validSalida  (vsal3),
      .readySalida  (rsal3),
      .fullSalida   (fsal3)
`ifdef DEMUX_ERR_CNT_EN
      ,
      .err_cnt      (err3)
`endif
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      val = 1'b0; sel = '0; ent = '0; rsal = '0;
      val3 = 1'b0; sel3 = '0; ent3 = '0; rsal3 = '0;
      #1;
      checks++;
      if (rdy_in !== 1'b0) begin
         errors++; $display("FAIL reset_ready_low got=%b exp=0", rdy_in);
      end
      step();
      step();
      checks++;
      if (vsal !== 4'b0000 || fsal !== 4'b0000 || sal !== 32'h0) begin
         errors++; $display("FAIL reset_outputs got v=%b f=%b s=%h exp v=0000 f=0000 s=0", vsal, fsal, sal);
      end
      checks++;
      if (rdy_in3 !== 1'b0) begin
         errors++; $display("FAIL reset_ready3_low got=%b exp=0", rdy_in3);
      end
`ifdef DEMUX_ERR_CNT_EN
      checks++;
      if (err4 !== 16'd0 || err3 !== 16'd0) begin
         errors++; $display("FAIL reset_err_cnt got=%0d/%0d exp=0/0", err4, err3);
      end
`endif
      reset = 1'b0;
      #1;
      checks++;
      if (rdy_in !== 1'b1 || rdy_in3 !== 1'b1) begin
         errors++; $display("FAIL idle_ready got=%b/%b exp=1/1", rdy_in, rdy_in3);
      end
   endtask

   task automatic test_routing();
      logic [7:0] exp_w;
      rsal = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         exp_w = 8'hA0 + 8'(k);
         sel = 2'(k); ent = exp_w; val = 1'b1;
         #1;
         checks++;
         if (rdy_in !== 1'b1) begin
            errors++; $display("FAIL route_ready ch%0d got=%b exp=1", k, rdy_in);
         end
         step();
         checks++;
         if (vsal !== (4'b0001 << k) || sal[k*8 +: 8] !== exp_w) begin
            errors++; $display("FAIL route_out ch%0d got v=%b d=%h exp v=%b d=%h",
                               k, vsal, sal[k*8 +: 8], 4'b0001 << k, exp_w);
         end
      end
      val = 1'b0;
      step();
      checks++;
      if (vsal !== 4'b0000) begin
         errors++; $display("FAIL route_pulse_end got=%b exp=0000", vsal);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_q[$];
      rsal = 4'b1011;
      sel = 2'd2; val = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ent = 8'hB0 + 8'(i);
         #1;
         checks++;
         if (rdy_in !== 1'b1) begin
            errors++; $display("FAIL bp_accept word%0d got=%b exp=1", i, rdy_in);
         end
         step();
      end
      ent = 8'hB4;
      #1;
      checks++;
      if (fsal !== 4'b0100 || rdy_in !== 1'b0 || sal[23:16] !== 8'hB0) begin
         errors++; $display("FAIL bp_full got f=%b r=%b h=%h exp f=0100 r=0 h=b0", fsal, rdy_in, sal[23:16]);
      end
      step();
      checks++;
      if (fsal !== 4'b0100 || rdy_in !== 1'b0) begin
         errors++; $display("FAIL bp_hold got f=%b r=%b exp f=0100 r=0", fsal, rdy_in);
      end
      rsal = 4'b1111;
      #1;
      checks++;
      if (rdy_in !== 1'b0) begin
         errors++; $display("FAIL bp_pop_same_cycle got=%b exp=0", rdy_in);
      end
      step();
      checks++;
      if (rdy_in !== 1'b1 || fsal !== 4'b0000 || sal[23:16] !== 8'hB1) begin
         errors++; $display("FAIL bp_space got r=%b f=%b h=%h exp r=1 f=0000 h=b1", rdy_in, fsal, sal[23:16]);
      end
      step();
      val = 1'b0;
      exp_q = '{8'hB2, 8'hB3, 8'hB4};
      while (exp_q.size() > 0) begin
         checks++;
         if (vsal[2] !== 1'b1 || sal[23:16] !== exp_q[0]) begin
            errors++; $display("FAIL bp_order got v=%b h=%h exp v=1 h=%h", vsal[2], sal[23:16], exp_q[0]);
         end
         void'(exp_q.pop_front());
         step();
      end
      checks++;
      if (vsal !== 4'b0000 || sal[23:16] !== 8'hB4) begin
         errors++; $display("FAIL bp_drained got v=%b h=%h exp v=0000 h=b4", vsal, sal[23:16]);
      end
   endtask

   task automatic test_concurrent_pops();
      rsal = 4'b0000;
      val = 1'b1;
      sel = 2'd0; ent = 8'hC0; step();
      sel = 2'd1; ent = 8'hC1; step();
      sel = 2'd0; ent = 8'hC2; step();
      sel = 2'd1; ent = 8'hC3; step();
      val = 1'b0;
      rsal = 4'b0011;
      #1;
      checks++;
      if (vsal !== 4'b0011 || sal[7:0] !== 8'hC0 || sal[15:8] !== 8'hC1) begin
         errors++; $display("FAIL pop2_first got v=%b h=%h/%h exp v=0011 h=c0/c1", vsal, sal[7:0], sal[15:8]);
      end
      step();
      checks++;
      if (vsal !== 4'b0011 || sal[7:0] !== 8'hC2 || sal[15:8] !== 8'hC3) begin
         errors++; $display("FAIL pop2_second got v=%b h=%h/%h exp v=0011 h=c2/c3", vsal, sal[7:0], sal[15:8]);
      end
      step();
      checks++;
      if (vsal !== 4'b0000) begin
         errors++; $display("FAIL pop2_drained got=%b exp=0000", vsal);
      end
   endtask

   task automatic test_out_of_range_and_reset();
      rsal3 = 3'b111;
      sel3 = 2'd3; ent3 = 8'hEE; val3 = 1'b1;
      #1;
      checks++;
      if (rdy_in3 !== 1'b1) begin
         errors++; $display("FAIL oor_ready got=%b exp=1", rdy_in3);
      end
      step();
      val3 = 1'b0;
      checks++;
      if (vsal3 !== 3'b000 || fsal3 !== 3'b000) begin
         errors++; $display("FAIL oor_dropped got v=%b f=%b exp v=000 f=000", vsal3, fsal3);
      end
`ifdef DEMUX_ERR_CNT_EN
      checks++;
      if (err3 !== 16'd1) begin
         errors++; $display("FAIL oor_err_cnt got=%0d exp=1", err3);
      end
`endif
      // Load words in both instances, then reset with a push still pending.
      rsal3 = 3'b000; rsal = 4'b0000;
      sel3 = 2'd1; ent3 = 8'hD1; val3 = 1'b1;
      sel = 2'd3; ent = 8'hD3; val = 1'b1;
      step();
      checks++;
      if (vsal3 !== 3'b010 || vsal !== 4'b1000) begin
         errors++; $display("FAIL pre_reset_loaded got v3=%b v=%b exp v3=010 v=1000", vsal3, vsal);
      end
      reset = 1'b1;
      rsal = 4'b1111;
      step();
      checks++;
      if (vsal !== 4'b0000 || vsal3 !== 3'b000 || fsal !== 4'b0000 || sal !== 32'h0) begin
         errors++; $display("FAIL mid_reset_clear got v=%b v3=%b f=%b s=%h exp all zero", vsal, vsal3, fsal, sal);
      end
`ifdef DEMUX_ERR_CNT_EN
      checks++;
      if (err3 !== 16'd0) begin
         errors++; $display("FAIL mid_reset_err_cnt got=%0d exp=0", err3);
      end
`endif
      reset = 1'b0;
      val = 1'b0; val3 = 1'b0;
      step();
      checks++;
      if (vsal !== 4'b0000 || vsal3 !== 3'b000 || rdy_in !== 1'b1) begin
         errors++; $display("FAIL post_reset_idle got v=%b v3=%b r=%b exp 0000/000/1", vsal, vsal3, rdy_in);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_routing();
      test_backpressure();
      test_concurrent_pops();
      test_out_of_range_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
